// File: rtl/mips32_pkg.sv
// Shared types for the MIPS32 multiply/divide unit: operation codes and FSM states.
package mips32_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/mips32_muldiv.sv
// Iterative MIPS32 HI/LO multiply/divide: one shift-add or restoring-subtract step per cycle.
// Divide datapath is present only when MIPS32_MULDIV_DIV_EN is defined.
module mips32_muldiv
  import mips32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int W  = WIDTH;
  localparam int CW = $clog2(W + 1);

  muldiv_state_t    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W:0]     acc_q, acc_d;
  logic [W-1:0]     opb_q, opb_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;

  logic             sgn_in;
  logic [W-1:0]     a_abs, b_abs;
  logic [W:0]       mul_u;
  logic [2*W-1:0]   prod;

  // Operands are converted to magnitudes on capture; sign is restored in FIX.
  assign sgn_in = ~op[0];
  assign a_abs  = (sgn_in && a[W-1]) ? -a : a;
  assign b_abs  = (sgn_in && b[W-1]) ? -b : b;
  // acc[2W] is always zero for multiply, so the sum cannot overflow W+1 bits.
  assign mul_u  = acc_q[0] ? acc_q[2*W:W] + {1'b0, opb_q} : acc_q[2*W:W];
  assign prod   = neg_q ? -acc_q[2*W-1:0] : acc_q[2*W-1:0];

`ifdef MIPS32_MULDIV_DIV_EN
  logic [W-1:0]     a_q, a_d;
  logic             nega_q, nega_d, bz_q, bz_d;
  logic [2*W:0]     div_sh;
  logic [W:0]       div_diff;
  logic [W-1:0]     q_fix, r_fix;

  assign div_sh   = {acc_q[2*W-1:0], 1'b0};
  assign div_diff = div_sh[2*W:W] - {1'b0, opb_q};
  assign q_fix    = neg_q  ? -acc_q[W-1:0]     : acc_q[W-1:0];
  assign r_fix    = nega_q ? -acc_q[2*W-1:W]   : acc_q[2*W-1:W];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
`ifdef MIPS32_MULDIV_DIV_EN
    a_d      = a_q;
    nega_d   = nega_q;
    bz_d     = bz_q;
`endif
    case (state_q)
      MD_IDLE, MD_DONE: begin
        if (start) begin
          state_d  = MD_CALC;
          cnt_d    = '0;
          acc_d    = {{(W+1){1'b0}}, a_abs};
          opb_d    = b_abs;
          is_div_d = op[1];
          neg_d    = sgn_in && (a[W-1] ^ b[W-1]);
`ifdef MIPS32_MULDIV_DIV_EN
          a_d      = a;
          nega_d   = sgn_in && a[W-1];
          bz_d     = (b == '0);
`endif
        end else if (state_q == MD_DONE) begin
          state_d = MD_IDLE;
        end
      end
      MD_CALC: begin
        if (cnt_q == CW'(W)) begin
          state_d = MD_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (!is_div_q) acc_d = {1'b0, mul_u, acc_q[W-1:1]};
`ifdef MIPS32_MULDIV_DIV_EN
          else acc_d = div_diff[W] ? div_sh : {div_diff, div_sh[W-1:1], 1'b1};
`endif
        end
      end
      MD_FIX: begin
        state_d = MD_DONE;
        dz_d    = 1'b0;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod;
        end else begin
`ifdef MIPS32_MULDIV_DIV_EN
          if (bz_q) begin
            dz_d = 1'b1;
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = q_fix;
            hi_d = r_fix;
          end
`else
          hi_d = '0;
          lo_d = '0;
`endif
        end
      end
      default: state_d = MD_IDLE;
    endcase
    busy_d = (state_d == MD_CALC) || (state_d == MD_FIX);
    done_d = (state_d == MD_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
`ifdef MIPS32_MULDIV_DIV_EN
      a_q      <= '0;
      nega_q   <= 1'b0;
      bz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
`ifdef MIPS32_MULDIV_DIV_EN
      a_q      <= a_d;
      nega_q   <= nega_d;
      bz_q     <= bz_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_mips32_muldiv.sv
// Directed bench for mips32_muldiv (WIDTH=32); divide expectations follow MIPS32_MULDIV_DIV_EN.
module tb_mips32_muldiv;
  import mips32_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [1:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done, dz;
  logic [W-1:0]  hi, lo;

  int checks   = 0;
  int failures = 0;

  mips32_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Edge 0 is the edge that samples start; returns the edge after which done first rose.
  task automatic issue(input muldiv_op_t o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input int inj_edge, output int done_edge);
    done_edge = -1;
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    for (int k = 1; k <= LAT + 4 && done_edge < 0; k++) begin
      if (k == inj_edge) begin
        op = MD_MULTU; a = 32'd9; b = 32'd9; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done && done_edge < 0) done_edge = k;
    end
  endtask

  task automatic run(input string tag, input muldiv_op_t o, input logic [W-1:0] av,
                     input logic [W-1:0] bv, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                     input logic edz, input int inj_edge);
    int de;
    issue(o, av, bv, inj_edge, de);
    chk({tag, "_lat"}, 64'(de), 64'(LAT));
    chk({tag, "_hi"}, 64'(hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(lo), 64'(elo));
    chk({tag, "_dz"}, 64'(dz), 64'(edz));
    @(posedge clk); #1;
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; op = MD_MULT; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_dz",   64'(dz), 64'd0);
    rst = 1'b0;

    run("multu_30x50", MD_MULTU, 32'd30, 32'd50, 32'd0, 32'd1500, 1'b0, 0);
    run("mult_m3x5",   MD_MULT,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0);
    run("multu_max",   MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    run("mult_max",    MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, 0);
`ifdef MIPS32_MULDIV_DIV_EN
    run("divu_35_15",  MD_DIVU, 32'd35, 32'd15, 32'd5, 32'd2, 1'b0, 0);
    run("div_m7_2",    MD_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    run("div_ovf",     MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 0);
    run("divu_dz",     MD_DIVU, 32'd20, 32'd0, 32'd20, 32'hFFFF_FFFF, 1'b1, 0);
    run("mul_clr_dz",  MD_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 0);
`else
    run("multu_prev",  MD_MULTU, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0, 0);
    run("divu_off",    MD_DIVU, 32'd35, 32'd15, 32'd0, 32'd0, 1'b0, 0);
`endif
    // start during busy at edge 5 must not disturb the 4*4 in flight
    run("busy_ign",    MD_MULTU, 32'd4, 32'd4, 32'd0, 32'd16, 1'b0, 5);

    // load nonzero hi/lo, then reset mid-operation at edge 10
    run("pre_rst",     MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 1'b0, 0);
    @(negedge clk);
    op = MD_MULTU; a = 32'd5; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    seen = 0;
    repeat (LAT + 4) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("abort_nodone", 64'(seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
